mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream controller for the 6-to-1, 4-bit data selector. It drives the selector's `sel` input, scanning channels 0..NUM_CH-1.
- It samples the selector's combinational `out` once per channel and assembles the values into one packed frame.
- The frame is presented downstream on a valid/ready handshake.
- It turns the stateless selector into a time-multiplexed acquisition path, with optional continuous scanning.

Parameters:
- NUM_CH, 6, channels scanned per frame; must be ≤ 2**SEL_W and ≥ 1.
- DW, 4, width of one channel sample (the selector's data width).
- SEL_W, 3, width of the `sel` output.
- SETTLE, 0, extra wait cycles after each `sel` change before sampling (0..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one scan; honoured only in IDLE.
- cont  in  1  continuous mode; sampled at the frame handshake.
- sel  out  SEL_W  channel select to the selector (registered).
- mux_out  in  DW  selector output (combinational function of `sel`).
- frame_data  out  NUM_CH*DW  assembled frame; channel k occupies bits [k*DW +: DW].
- frame_valid  out  1  frame available.
- frame_ready  in  1  downstream accepts the frame.
- busy  out  1  high in SCAN or OUT.
- start_drop  out  1  one-cycle pulse when `start` arrives while not in IDLE.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, sel=0, ch=0, settle_cnt=0, frame_data=0, frame_valid=0, busy=0, start_drop=0.
- Reset has priority over every other input in the same cycle.
- IDLE:
  - sel holds 0.
  - start=1 → SCAN, with ch=0, sel=0, settle_cnt=0.
- SCAN:
  - sel=ch. If settle_cnt<SETTLE, increment settle_cnt.
  - Otherwise, capture mux_out into frame_data[ch*DW +: DW] and clear settle_cnt.
    - If ch==NUM_CH-1 → OUT.
    - Else ch++ and sel=ch+1, both registered.
  - `mux_out` is sampled in the same cycle that `sel` shows the channel. There is no extra pipeline stage, because the selector is combinational.
- Latency: start accepted at edge T → frame_valid=1 from cycle T+1+NUM_CH*(SETTLE+1). With defaults, that is start + 7 cycles.
- OUT:
  - frame_valid=1; frame_data is stable until handshake; sel holds the last channel.
  - On frame_valid&&frame_ready:
    - frame_valid drops next cycle.
    - If cont=1 → SCAN with ch=0 (no bubble; sel=0 next cycle).
    - Else → IDLE.
  - Without frame_ready, OUT is held indefinitely. No samples are taken and no data changes.
- start handling: start while state≠IDLE is ignored and pulses start_drop for one cycle. This includes start in the same cycle as a handshake.
- frame_data bits of a new scan are overwritten channel by channel; unwritten channels keep the previous frame's values. frame_data is only meaningful while frame_valid=1.
- Reset mid-scan or mid-OUT discards the partial or pending frame; next cycle is IDLE with reset values.
- Channels numbered ≥NUM_CH are never driven on sel.
- busy=1 exactly when state∈{SCAN,OUT}.

Decomposition:
- Shared package `mux_scan_pkg`: state enum {IDLE, SCAN, OUT}, default constants for NUM_CH/DW/SEL_W.
- One natural sub-module, `settle_counter`: a SETTLE-cycle down-counter with load/done. Everything else stays in the top-level FSM.

Test Plan:
- Defaults; the bench models the selector with data_k = k+1. Pulse start → sel walks 0,1,2,3,4,5 on consecutive cycles; frame_valid at start+7; frame_data=24'h654321.
- SETTLE=2, same data → each sel value is held 3 cycles; frame_valid at start+19; same frame_data.
- frame_ready held low 10 cycles after valid; change the selector data mid-hold → frame_data stays 24'h654321 and sel stays 5. Raise ready → valid drops next cycle, state IDLE.
- cont=1 with frame_ready=1 continuously → back-to-back frames every 7 cycles, sel sequence 0..5,0..5 with no gap. Second frame reflects the updated data (e.g. 24'hABCDEF).
- Pulse start during SCAN (cycle 3) → start_drop=1 for one cycle; the scan is unaffected and exactly one frame is produced.
- Assert reset at sel=3 mid-scan → next cycle sel=0, busy=0, frame_valid=0, frame_data=0. A new start yields a correct full frame.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state type and default geometry for the mux scan sequencer
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 6;
    localparam int DEF_DW     = 4;
    localparam int DEF_SEL_W  = 3;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - frame valid/ready channel between sequencer and consumer
interface mux_scan_sequencer_if #(
    parameter int W = 24
);
    logic [W-1:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - per-channel settle wait; done when the loaded count has drained
module settle_counter #(
    parameter int SETTLE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd0);
endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scans the 6:1 selector channel by channel and emits one packed frame
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cont,
    output logic [SEL_W-1:0]     sel,
    input  logic [DW-1:0]        mux_out,
    mux_scan_sequencer_if.master frm,
    output logic                 busy,
    output logic                 start_drop
);
    state_t state;
    logic   settle_load;
    logic   settle_dec;
    logic   settle_done;
    logic   last_ch;

    // sel doubles as the channel index: it is only ever advanced in lockstep with the capture
    assign last_ch = (sel == SEL_W'(NUM_CH - 1));

    always_comb begin
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        case (state)
            IDLE: settle_load = start;
            SCAN: begin
                if (!settle_done) settle_dec  = 1'b1;
                else              settle_load = !last_ch;
            end
            OUT:     settle_load = frm.frame_ready && cont;
            default: settle_load = 1'b0;
        endcase
    end

    settle_counter #(.SETTLE(SETTLE)) u_settle (
        .clk   (clk),
        .reset (reset),
        .load  (settle_load),
        .dec   (settle_dec),
        .done  (settle_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sel             <= '0;
            frm.frame_data  <= '0;
            frm.frame_valid <= 1'b0;
            busy            <= 1'b0;
            start_drop      <= 1'b0;
        end else begin
            start_drop <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // selector is combinational, so mux_out already reflects the sel shown this cycle
                    if (settle_done) begin
                        frm.frame_data[int'(sel)*DW +: DW] <= mux_out;
                        if (last_ch) begin
                            state           <= OUT;
                            frm.frame_valid <= 1'b1;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (frm.frame_ready) begin
                        frm.frame_valid <= 1'b0;
                        sel             <= '0;
                        if (cont) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - bench for mux_scan_sequencer with SETTLE=0 and SETTLE=2 instances
module tb_mux_scan_sequencer;
    localparam int NCH = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        rdy  [2];
    logic [3:0]  dat  [NCH];
    logic [2:0]  sel  [2];
    logic [3:0]  mux  [2];
    logic        busy [2];
    logic        drop [2];
    logic [23:0] fd   [2];
    logic        fv   [2];

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    int          m_mode  [2] = '{0, 0};
    int          m_p     [2] = '{0, 0};
    logic [2:0]  m_sel   [2] = '{3'd0, 3'd0};
    logic [23:0] m_frame [2] = '{24'd0, 24'd0};
    logic        m_drop  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.W(24)) frm0 ();
    mux_scan_sequencer_if #(.W(24)) frm1 ();

    assign frm0.frame_ready = rdy[0];
    assign frm1.frame_ready = rdy[1];
    assign fd[0] = frm0.frame_data;
    assign fd[1] = frm1.frame_data;
    assign fv[0] = frm0.frame_valid;
    assign fv[1] = frm1.frame_valid;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mux[i] = 4'h0;
            for (int k = 0; k < NCH; k++)
                if (int'(sel[i]) == k) mux[i] = dat[k];
        end
    end

    mux_scan_sequencer #(.NUM_CH(6), .DW(4), .SEL_W(3), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .sel(sel[0]),
        .mux_out(mux[0]), .frm(frm0), .busy(busy[0]), .start_drop(drop[0]));

    mux_scan_sequencer #(.NUM_CH(6), .DW(4), .SEL_W(3), .SETTLE(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .sel(sel[1]),
        .mux_out(mux[1]), .frm(frm1), .busy(busy[1]), .start_drop(drop[1]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input logic [23:0] v);
        for (int k = 0; k < NCH; k++) dat[k] = v[k*4 +: 4];
    endtask

    // Reference: a scan is a run of phase counter p; every (s+1)-th cycle captures channel p/(s+1)
    always @(posedge clk) begin
        int s;
        int k;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? 0 : 2;
            if (reset) begin
                m_mode[i] = 0; m_p[i] = 0; m_sel[i] = 3'd0; m_frame[i] = 24'd0; m_drop[i] = 1'b0;
            end else begin
                m_drop[i] = start && (m_mode[i] != 0);
                case (m_mode[i])
                    0: if (start) begin m_mode[i] = 1; m_p[i] = 0; end
                    1: begin
                        if (m_p[i] % (s + 1) == s) begin
                            k = m_p[i] / (s + 1);
                            m_frame[i][k*4 +: 4] = dat[k];
                            if (k == NCH - 1) m_mode[i] = 2;
                        end
                        m_p[i] = m_p[i] + 1;
                    end
                    default: if (rdy[i]) begin m_mode[i] = cont ? 1 : 0; m_p[i] = 0; end
                endcase
                if (m_mode[i] == 1)      m_sel[i] = 3'(m_p[i] / (s + 1));
                else if (m_mode[i] == 0) m_sel[i] = 3'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check(i == 0 ? "model_sel0"   : "model_sel1",   32'(sel[i]), 32'(m_sel[i]));
                check(i == 0 ? "model_valid0" : "model_valid1", 32'(fv[i]),  32'(m_mode[i] == 2));
                check(i == 0 ? "model_busy0"  : "model_busy1",  32'(busy[i]), 32'(m_mode[i] != 0));
                check(i == 0 ? "model_drop0"  : "model_drop1",  32'(drop[i]), 32'(m_drop[i]));
                check(i == 0 ? "model_frame0" : "model_frame1", 32'(fd[i]),  32'(m_frame[i]));
            end
        end
    end

    initial begin
        int lat0, lat1, v1, v2, frames;
        bit hit;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        set_dat(24'h654321);
        step();
        chk_on = 1'b1;
        step();
        step();
        check("rst_sel", 32'(sel[0]), 0);
        check("rst_valid", 32'(fv[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_frame", 32'(fd[0]), 0);
        reset = 1'b0;

        // single scan, ready held low: channel walk and latency for both settle settings
        start = 1'b1;
        lat0 = 0;
        lat1 = 0;
        for (int n = 1; n <= 40 && (lat0 == 0 || lat1 == 0); n++) begin
            step();
            start = 1'b0;
            if (n <= 6)  check("walk_sel0", 32'(sel[0]), 32'(n - 1));
            if (n <= 18) check("walk_sel1", 32'(sel[1]), 32'((n - 1) / 3));
            if (lat0 == 0 && fv[0]) lat0 = n;
            if (lat1 == 0 && fv[1]) lat1 = n;
        end
        check("latency0", lat0, 7);
        check("latency1", lat1, 19);
        check("frame0", 32'(fd[0]), 32'h654321);
        check("frame1", 32'(fd[1]), 32'h654321);

        // hold without ready while the selector data changes underneath
        set_dat(24'h9a7b3c);
        repeat (10) step();
        check("hold_frame0", 32'(fd[0]), 32'h654321);
        check("hold_sel0", 32'(sel[0]), 5);
        check("hold_valid0", 32'(fv[0]), 1);
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        step();
        check("release_valid0", 32'(fv[0]), 0);
        check("release_busy0", 32'(busy[0]), 0);
        check("release_busy1", 32'(busy[1]), 0);

        // continuous mode: back-to-back frames, second one sees updated data
        set_dat(24'h654321);
        cont = 1'b1;
        start = 1'b1;
        v1 = 0;
        v2 = 0;
        for (int n = 1; n <= 60 && v2 == 0; n++) begin
            step();
            start = 1'b0;
            if (fv[0] && v1 == 0) begin
                v1 = n;
                check("cont_frame_a", 32'(fd[0]), 32'h654321);
                set_dat(24'habcdef);
            end else if (fv[0] && v1 != 0) begin
                v2 = n;
                check("cont_frame_b", 32'(fd[0]), 32'habcdef);
            end
        end
        check("cont_first", v1, 7);
        check("cont_gap", v2 - v1, 7);
        cont = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 80 && !hit; n++) begin
            step();
            hit = !busy[0] && !busy[1];
        end
        check("cont_drain", 32'(hit), 1);

        // start during a scan is dropped and flagged
        set_dat(24'h654321);
        start = 1'b1;
        frames = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            start = (n == 3);
            if (n == 3) check("drop_before", 32'(drop[0]), 0);
            if (n == 4) check("drop_pulse", 32'(drop[0]), 1);
            if (n == 5) check("drop_after", 32'(drop[0]), 0);
            if (fv[0]) begin
                frames++;
                check("drop_frame", 32'(fd[0]), 32'h654321);
            end
        end
        check("drop_frames", frames, 1);

        // reset mid-scan at sel=3, then a clean scan
        start = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            step();
            start = 1'b0;
            hit = (sel[0] == 3'd3);
        end
        check("reach_sel3", 32'(hit), 1);
        reset = 1'b1;
        step();
        check("midrst_sel", 32'(sel[0]), 0);
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_valid", 32'(fv[0]), 0);
        check("midrst_frame", 32'(fd[0]), 0);
        reset = 1'b0;
        start = 1'b1;
        lat0 = 0;
        for (int n = 1; n <= 20 && lat0 == 0; n++) begin
            step();
            start = 1'b0;
            if (fv[0]) lat0 = n;
        end
        check("rescan_latency", lat0, 7);
        check("rescan_frame", 32'(fd[0]), 32'h654321);

        // randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            step();
            start  = ($urandom_range(0, 7) == 0);
            cont   = ($urandom_range(0, 3) == 0);
            rdy[0] = 1'($urandom_range(0, 1));
            rdy[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dat[$urandom_range(0, NCH - 1)] = 4'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
